// File: rtl/uart_rx_fsm_pkg.sv
// Shared types and constants for the UART receive sequencer.
package uart_rx_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      DONE   = 3'd5
   } state_e;

   localparam logic [5:0] PRESCALE_8  = 6'd8;
   localparam logic [5:0] PRESCALE_16 = 6'd16;
   localparam logic [5:0] PRESCALE_32 = 6'd32;

   localparam int CHK_OFFSET = 2;
   localparam int MID_HALF   = 1;

   function automatic logic prescale_legal(input logic [5:0] p);
      return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
   endfunction

endpackage

// File: rtl/uart_rx_fsm_if.sv
// Sequencer <-> receive datapath signal bundle; master is the sequencer side.
interface uart_rx_fsm_if #(parameter int BIT_CNT_W = 4);
   logic                 rx_in;
   logic                 par_en;
   logic [5:0]           prescale;
   logic [4:0]           edge_count;
   logic                 edge_count_done;
   logic                 strt_glitch;
   logic                 par_err;
   logic                 stp_err;
   logic                 edge_cnt_en;
   logic                 data_sample_en;
   logic                 deser_en;
   logic                 strt_chk_en;
   logic                 par_chk_en;
   logic                 stp_chk_en;
   logic [BIT_CNT_W-1:0] bit_count;
   logic                 data_valid;
   logic                 frame_err;

   modport master (
      input  rx_in, par_en, prescale, edge_count, edge_count_done,
             strt_glitch, par_err, stp_err,
      output edge_cnt_en, data_sample_en, deser_en, strt_chk_en, par_chk_en,
             stp_chk_en, bit_count, data_valid, frame_err
   );

   modport slave (
      output rx_in, par_en, prescale, edge_count, edge_count_done,
             strt_glitch, par_err, stp_err,
      input  edge_cnt_en, data_sample_en, deser_en, strt_chk_en, par_chk_en,
             stp_chk_en, bit_count, data_valid, frame_err
   );
endinterface

// File: rtl/uart_rx_fsm_strobe_decode.sv
// Combinational strobe decode from registered state and the current edge position.
module uart_rx_strobe_decode
   import uart_rx_pkg::*;
(
   input  state_e     state,
   input  logic [4:0] edge_count,
   input  logic [5:0] prescale,
   output logic       edge_cnt_en,
   output logic       data_sample_en,
   output logic       deser_en,
   output logic       strt_chk_en,
   output logic       par_chk_en,
   output logic       stp_chk_en
);
   logic [5:0] half;
   logic [5:0] ec;
   logic       mid;
   logic       chk;

   assign half = prescale >> 1;
   assign ec   = {1'b0, edge_count};
   // ec+1 >= half is ec >= half-1 without underflow
   assign mid  = (ec + 6'(MID_HALF) >= half) && (ec <= half + 6'(MID_HALF));
   assign chk  = (ec == half + 6'(CHK_OFFSET));

   assign edge_cnt_en    = (state == START) || (state == DATA) ||
                           (state == PARITY) || (state == STOP);
   assign data_sample_en = edge_cnt_en && mid;
   assign strt_chk_en    = (state == START)  && chk;
   assign deser_en       = (state == DATA)   && chk;
   assign par_chk_en     = (state == PARITY) && chk;
   assign stp_chk_en     = (state == STOP)   && chk;
endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive sequencer: frame state, data bit index and sticky frame error flags.
module uart_rx_fsm
   import uart_rx_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int BIT_CNT_W  = 4
) (
   input logic          clk,
   input logic          reset,
   uart_rx_fsm_if.master bus
);
   state_e               state;
   logic [BIT_CNT_W-1:0] bit_count;
   logic                 par_flag;
   logic                 stp_flag;
   logic                 cnt_en, smp_en, dsr_en, strt_chk, par_chk, stp_chk;

   uart_rx_strobe_decode u_dec (
      .state          (state),
      .edge_count     (bus.edge_count),
      .prescale       (bus.prescale),
      .edge_cnt_en    (cnt_en),
      .data_sample_en (smp_en),
      .deser_en       (dsr_en),
      .strt_chk_en    (strt_chk),
      .par_chk_en     (par_chk),
      .stp_chk_en     (stp_chk)
   );

   assign bus.edge_cnt_en    = cnt_en;
   assign bus.data_sample_en = smp_en;
   assign bus.deser_en       = dsr_en;
   assign bus.strt_chk_en    = strt_chk;
   assign bus.par_chk_en     = par_chk;
   assign bus.stp_chk_en     = stp_chk;
   assign bus.bit_count      = bit_count;
   assign bus.data_valid     = (state == DONE) && !(par_flag || stp_flag);
   assign bus.frame_err      = (state == DONE) &&  (par_flag || stp_flag);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         bit_count <= '0;
         par_flag  <= 1'b0;
         stp_flag  <= 1'b0;
      end else begin
         case (state)
            IDLE:
               if (!bus.rx_in && prescale_legal(bus.prescale)) state <= START;
            START:
               // a failed start check wins even on the last edge of the bit
               if (strt_chk && bus.strt_glitch) begin
                  state <= IDLE;
               end else if (bus.edge_count_done) begin
                  state     <= DATA;
                  bit_count <= '0;
                  par_flag  <= 1'b0;
                  stp_flag  <= 1'b0;
               end
            DATA:
               if (bus.edge_count_done) begin
                  if (bit_count == BIT_CNT_W'(DATA_WIDTH - 1)) begin
                     bit_count <= '0;
                     state     <= bus.par_en ? PARITY : STOP;
                  end else begin
                     bit_count <= bit_count + 1'b1;
                  end
               end
            PARITY: begin
               if (par_chk) par_flag <= par_flag | bus.par_err;
               if (bus.edge_count_done) state <= STOP;
            end
            STOP: begin
               if (stp_chk) stp_flag <= stp_flag | bus.stp_err;
               if (bus.edge_count_done) state <= DONE;
            end
            DONE:
               state <= bus.rx_in ? IDLE : START;
            default:
               state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm: frame table plus glitch, illegal prescale and reset sequences.
module tb_uart_rx_fsm;
   localparam int DW = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   uart_rx_fsm_if #(.BIT_CNT_W(4)) bus ();

   uart_rx_fsm #(.DATA_WIDTH(DW), .BIT_CNT_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always_ff @(posedge clk) cyc <= cyc + 1;

   // edge counter model: counts 0..prescale-1 while enabled, clears otherwise
   logic [4:0] ec;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) ec <= '0;
      else if (!bus.edge_cnt_en || bus.edge_count_done) ec <= '0;
      else ec <= ec + 5'd1;
   end
   assign bus.edge_count      = ec;
   assign bus.edge_count_done = bus.edge_cnt_en && ({1'b0, ec} == bus.prescale - 6'd1);

   typedef struct {
      logic [5:0] ps;
      logic       pe;
      logic [7:0] d;
      logic       perr;
      logic       serr;
      logic       next_low;
      logic       ok;
   } frame_t;

   function automatic logic [11:0] exp_bit(input int ps, input bit pe, input int b, input int e);
      int       h, nb;
      bit       c;
      logic [3:0] bc;
      h  = ps / 2;
      nb = DW + 2 + (pe ? 1 : 0);
      c  = (e == h + 2);
      bc = (b >= 1 && b <= DW) ? 4'(b - 1) : 4'd0;
      return {1'b1, (e >= h - 1 && e <= h + 1), (b >= 1 && b <= DW && c), (b == 0 && c),
              (pe && b == DW + 1 && c), (b == nb - 1 && c), 2'b00, bc};
   endfunction

   task automatic chk(input string nm, input logic [11:0] exp);
      logic [11:0] act;
      act = {bus.edge_cnt_en, bus.data_sample_en, bus.deser_en, bus.strt_chk_en,
             bus.par_chk_en, bus.stp_chk_en, bus.data_valid, bus.frame_err, bus.bit_count};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
      end
   endtask

   task automatic drive_bit(input frame_t f, input int b, input int e);
      int h, nb;
      h  = f.ps / 2;
      nb = DW + 2 + (f.pe ? 1 : 0);
      if (b == 0) bus.rx_in = 1'b0;
      else if (b <= DW) bus.rx_in = f.d[b - 1];
      else if (f.pe && b == DW + 1) bus.rx_in = ^f.d;
      else bus.rx_in = 1'b1;
      // checker results are driven "bad" outside their check cycle
      bus.strt_glitch = (b == 0 && e == h + 2) ? 1'b0 : 1'b1;
      bus.par_err     = (f.pe && b == DW + 1 && e == h + 2) ? f.perr : 1'b1;
      bus.stp_err     = (b == nb - 1 && e == h + 2) ? f.serr : 1'b1;
   endtask

   task automatic start_from_idle();
      @(negedge clk);
      chk("idle", 12'h000);
      bus.rx_in       = 1'b0;
      bus.strt_glitch = 1'b0;
      bus.par_err     = 1'b0;
      bus.stp_err     = 1'b0;
   endtask

   task automatic run_frame(input frame_t f, output int done_cyc);
      int nb;
      nb = DW + 2 + (f.pe ? 1 : 0);
      for (int b = 0; b < nb; b++) begin
         for (int e = 0; e < int'(f.ps); e++) begin
            @(negedge clk);
            chk("frame", exp_bit(f.ps, f.pe, b, e));
            drive_bit(f, b, e);
         end
      end
      @(negedge clk);
      chk("done", {6'b0, f.ok, !f.ok, 4'd0});
      done_cyc        = cyc;
      bus.rx_in       = !f.next_low;
      bus.strt_glitch = 1'b0;
      bus.par_err     = 1'b0;
      bus.stp_err     = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      frame_t tbl[7];
      int     dcyc[7];
      int     tmp;
      bit     chained;
      bit     stop_loop;
      frame_t fr;

      tbl[0] = '{6'd8,  1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[1] = '{6'd16, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[2] = '{6'd16, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[3] = '{6'd32, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[4] = '{6'd8,  1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[5] = '{6'd16, 1'b0, 8'h55, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[6] = '{6'd16, 1'b0, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b1};

      bus.rx_in = 1'b1; bus.par_en = 1'b0; bus.prescale = 6'd8;
      bus.strt_glitch = 1'b0; bus.par_err = 1'b0; bus.stp_err = 1'b0;

      @(negedge clk);
      chk("reset", 12'h000);
      @(negedge clk);
      reset = 1'b0;

      chained = 1'b0;
      for (int i = 0; i < 7; i++) begin
         bus.prescale = tbl[i].ps;
         bus.par_en   = tbl[i].pe;
         if (!chained) start_from_idle();
         run_frame(tbl[i], dcyc[i]);
         chained = tbl[i].next_low;
      end
      checks++;
      if (dcyc[6] - dcyc[5] != 161) begin
         errors++;
         $display("FAIL b2b_spacing got=%0d want=161", dcyc[6] - dcyc[5]);
      end

      // start glitch at prescale 32
      @(negedge clk);
      bus.prescale = 6'd32; bus.par_en = 1'b0;
      start_from_idle();
      for (int e = 0; e <= 18; e++) begin
         @(negedge clk);
         chk("glitch_start", exp_bit(32, 1'b0, 0, e));
         if (e == 9) bus.rx_in = 1'b1;
         bus.strt_glitch = (e == 18);
      end
      @(negedge clk);
      bus.strt_glitch = 1'b0;
      chk("glitch_idle", 12'h000);
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         chk("glitch_after", 12'h000);
      end

      // illegal prescale: line activity must not leave IDLE
      bus.prescale = 6'd12;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         chk("illegal_ps", 12'h000);
         bus.rx_in = k[0];
      end
      @(negedge clk);
      bus.rx_in = 1'b1;
      chk("illegal_ps_end", 12'h000);

      // reset in the middle of data bit 4
      bus.prescale = 6'd16; bus.par_en = 1'b0;
      fr = '{6'd16, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b1};
      start_from_idle();
      stop_loop = 1'b0;
      for (int b = 0; b < 6 && !stop_loop; b++) begin
         for (int e = 0; e < 16 && !stop_loop; e++) begin
            @(negedge clk);
            chk("pre_reset", exp_bit(16, 1'b0, b, e));
            drive_bit(fr, b, e);
            if (b == 5 && e == 3) stop_loop = 1'b1;
         end
      end
      #1 reset = 1'b1;
      #1 chk("reset_mid", 12'h000);
      @(negedge clk);
      chk("reset_hold", 12'h000);
      reset = 1'b0;
      bus.rx_in = 1'b1; bus.strt_glitch = 1'b0; bus.par_err = 1'b0; bus.stp_err = 1'b0;
      @(negedge clk);
      chk("reset_after", 12'h000);
      fr = '{6'd16, 1'b0, 8'h81, 1'b0, 1'b0, 1'b0, 1'b1};
      start_from_idle();
      run_frame(fr, tmp);
      @(negedge clk);
      chk("final_idle", 12'h000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
